ft245_byte_unpacker: RTL and testbench

//  Sits directly downstream of the FT245 FIFO read interface and consumes its received byte stream.

---
 rtl/ft245_byte_unpacker.sv | 119 +++++++++++
 tb/tb_ft245_byte_unpacker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_byte_unpacker.sv
// Sync-hunting byte unpacker: packs payload bytes little-endian into samples and queues them in an output FIFO.
// A sample is visible 1 clk after its final byte is accepted; byte_ready drops while the FIFO is full.
module ft245_byte_unpacker #(
    parameter int          SAMPLE_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                byte_data,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic [8*SAMPLE_BYTES-1:0] sample_data,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      sample_last,
    output logic                      in_frame,
    output logic [7:0]                sync_err_count
);
    localparam int SW = 8 * SAMPLE_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

    state_t          state, state_nxt;
    logic [1:0]      idx;
    logic [8:0]      remaining;
    logic [SW-1:0]   sreg, sample_nxt;
    logic [SW:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            accept, pop, push, push_last, last_byte;

    // byte_ready looks only at the registered count, never at sample_ready
    assign byte_ready   = !rst && (count < CW'(FIFO_DEPTH));
    assign accept       = byte_valid && byte_ready;
    assign sample_valid = (count != '0);
    assign pop          = sample_valid && sample_ready;
    assign last_byte    = (idx == 2'(SAMPLE_BYTES - 1));
    assign {sample_last, sample_data} = sample_valid ? mem[rd_ptr] : '0;

    always_comb begin
        sample_nxt = sreg;
        sample_nxt[8*idx +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_last = 1'b0;
        case (state)
            HUNT:    if (accept && byte_data == SYNC_BYTE) state_nxt = LEN;
            LEN:     if (accept) state_nxt = PAYLOAD;
            PAYLOAD: begin
                if (accept && last_byte) begin
                    push      = 1'b1;
                    push_last = (remaining == 9'd1);
                    if (push_last) state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            remaining      <= '0;
            sreg           <= '0;
            sync_err_count <= '0;
            in_frame       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            in_frame <= (state_nxt != HUNT);
            if (accept) begin
                case (state)
                    HUNT: begin
                        if (byte_data != SYNC_BYTE && sync_err_count != 8'hFF)
                            sync_err_count <= sync_err_count + 8'd1;
                    end
                    LEN: begin
                        // a zero length byte encodes a full 256-sample frame
                        remaining <= (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
                        idx       <= '0;
                    end
                    PAYLOAD: begin
                        sreg <= sample_nxt;
                        if (last_byte) begin
                            idx       <= '0;
                            remaining <= remaining - 9'd1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_last, sample_nxt};
    end
endmodule

// File: tb/tb_ft245_byte_unpacker.sv
// Randomized bench for ft245_byte_unpacker: expected samples are derived per frame from the bytes sent.
module tb_ft245_byte_unpacker;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        sample_last;
    logic        in_frame;
    logic [7:0]  sync_err_count;

    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 0;
    bit          gap_en = 1'b0;
    int          sent = 0;
    int          exp_err = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    ft245_byte_unpacker #(
        .SAMPLE_BYTES(2),
        .SYNC_BYTE(SYNC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_last(sample_last),
        .in_frame(in_frame),
        .sync_err_count(sync_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // consumer: picks sample_ready for the coming edge, then scores any pop it implies
    always @(negedge clk) begin
        case (ready_mode)
            0:       sample_ready = 1'b0;
            1:       sample_ready = 1'b1;
            default: sample_ready = ($urandom_range(0, 9) >= 3);
        endcase
        if (!rst && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sample_data", 32'(sample_data), 32'(mon_e[15:0]));
                check("sample_last", 32'(sample_last), 32'(mon_e[16]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (gap_en)
            while ($urandom_range(0, 9) < 3) @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check("byte_accept_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        sent++;
    endtask

    task automatic send_sample(input logic [15:0] s, input bit last);
        exp_q.push_back({last, s});
        send_byte(s[7:0]);
        send_byte(s[15:8]);
    endtask

    task automatic send_frame(input logic [7:0] len);
        int n;
        n = (len == 8'd0) ? 256 : int'(len);
        send_byte(SYNC);
        send_byte(len);
        for (int i = 0; i < n; i++) send_sample(16'($urandom), i == n - 1);
    endtask

    task automatic send_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b);
            exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_in_frame", 32'(in_frame), 32'd0);
        check("rst_err_count", 32'(sync_err_count), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_byte_ready", 32'(byte_ready), 32'd1);
        check("post_rst_sample_data", 32'(sample_data), 32'd0);
        @(negedge clk);

        // T1: two-sample frame, latency and end-of-frame state
        ready_mode = 1;
        send_byte(SYNC);
        check("t1_in_frame_len", 32'(in_frame), 32'd1);
        send_byte(8'h02);
        exp_q.push_back({1'b0, 16'h1234});
        send_byte(8'h34);
        check("t1_no_early_valid", 32'(sample_valid), 32'd0);
        send_byte(8'h12);
        check("t1_latency_s0", 32'(sample_valid), 32'd1);
        exp_q.push_back({1'b1, 16'h5678});
        send_byte(8'h78);
        send_byte(8'h56);
        check("t1_latency_s1", 32'(sample_valid), 32'd1);
        check("t1_hunt_after", 32'(in_frame), 32'd0);
        drain("t1_drain");

        // T2: sync errors and saturation
        send_byte(8'h00);
        send_byte(8'hFF);
        exp_err += 2;
        send_byte(SYNC);
        send_byte(8'h01);
        send_sample(16'hABCD, 1'b1);
        drain("t2_drain");
        check("t2_err_count", 32'(sync_err_count), 32'(exp_err));
        send_junk(300);
        check("t2_err_saturate", 32'(sync_err_count), 32'd255);

        // T3: back-pressure with a stalled consumer
        ready_mode = 0;
        sent = 0;
        fork
            begin
                send_byte(SYNC);
                send_byte(8'd6);
                for (int i = 0; i < 6; i++) send_sample(16'($urandom), i == 5);
            end
            begin
                int n = 0;
                while (sent < 10 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                repeat (4) @(negedge clk);
                check("t3_ready_low", 32'(byte_ready), 32'd0);
                check("t3_stalled_at", 32'(sent), 32'd10);
                check("t3_fifo_valid", 32'(sample_valid), 32'd1);
                ready_mode = 1;
            end
        join
        drain("t3_drain");

        // T4: length byte 0 means 256 samples, then a fresh frame
        send_frame(8'd0);
        send_frame(8'd1);
        drain("t4_drain");

        // T5: reset mid-frame with one sample buffered
        ready_mode = 0;
        send_byte(SYNC);
        send_byte(8'd4);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("t5_buffered", 32'(sample_valid), 32'd1);
        check("t5_in_frame", 32'(in_frame), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_byte_ready", 32'(byte_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_sample_valid", 32'(sample_valid), 32'd0);
        check("t5_in_frame_clr", 32'(in_frame), 32'd0);
        check("t5_err_clr", 32'(sync_err_count), 32'd0);
        check("t5_byte_ready", 32'(byte_ready), 32'd1);
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        ready_mode = 1;
        send_byte(SYNC);
        send_byte(8'h01);
        send_sample(16'h2211, 1'b1);
        drain("t5_drain");

        // T6: random frames with gaps on both sides
        gap_en = 1'b1;
        ready_mode = 2;
        for (int f = 0; f < 50; f++) begin
            send_junk($urandom_range(0, 3));
            send_frame(8'($urandom_range(1, 8)));
        end
        gap_en = 1'b0;
        drain("t6_drain");
        check("t6_err_count", 32'(sync_err_count), 32'(exp_err));
        check("t6_in_frame", 32'(in_frame), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
